// File: rtl/ps2_key_event_ctrl_pkg.sv
// Shared PS/2 definitions: special bytes, parser state encoding and event-word layout.
// Used by the receiver, the key-event sequencer and the command logic.
package ps2_key_event_ctrl_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERRF   = 8'hFF;

    localparam int EV_W       = 10;
    localparam int EV_EXT_BIT = 9;
    localparam int EV_BRK_BIT = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_EXT     = 2'b01,
        ST_BRK     = 2'b10,
        ST_EXT_BRK = 2'b11
    } state_e;

    // Device-status bytes that carry no key information when seen outside a sequence.
    function automatic logic is_status_byte(input logic [7:0] b);
        return (b == PS2_ERR0) || (b == PS2_BAT) || (b == PS2_ECHO) ||
               (b == PS2_ACK)  || (b == PS2_RESEND) || (b == PS2_ERRF);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event queue; a push into a full queue is accepted only
// when a pop frees a slot in the same cycle.
module ps2_event_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset too, so the head outputs read zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// Turns the PS/2 receiver byte stream into {extended, break, code} key events,
// with prefix stripping, status-byte filtering, inter-byte timeout and an event queue.
module ps2_key_event_ctrl
    import ps2_key_event_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_break,
    output logic       ev_ext,
    output logic       busy,
    output logic       overflow,
    input  logic       clr_overflow
);

    localparam int               CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              overflow_q, overflow_d;
    logic              emit, timeout, drop, is_ext, is_brk;
    logic              fifo_pop, fifo_empty, fifo_full;
    logic [EV_W-1:0]   ev_word, head;

    assign timeout = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);
    assign is_ext  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    assign is_brk  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
    assign ev_word = {is_ext, is_brk, rx_data};

    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        state_d = state_q;
        emit    = 1'b0;
        if (rx_done_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == PS2_EXT)          state_d = ST_EXT;
                    else if (rx_data == PS2_BRK)     state_d = ST_BRK;
                    else if (!is_status_byte(rx_data)) emit  = 1'b1;
                end
                ST_EXT: begin
                    if (rx_data == PS2_BRK)          state_d = ST_EXT_BRK;
                    else if (rx_data != PS2_EXT) begin
                        emit    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (rx_data == PS2_EXT)          state_d = ST_EXT_BRK;
                    else if (rx_data != PS2_BRK) begin
                        emit    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    if (rx_data != PS2_EXT && rx_data != PS2_BRK) begin
                        emit    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (timeout) begin
            // A truncated sequence is abandoned silently.
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        if (rx_done_tick || (state_q == ST_IDLE) || timeout) cnt_d = '0;
        else                                                cnt_d = cnt_q + CNT_W'(1);
    end

    assign fifo_pop   = ev_valid && ev_ready;
    assign drop       = emit && fifo_full && !fifo_pop;
    assign overflow_d = drop ? 1'b1 : (clr_overflow ? 1'b0 : overflow_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    ps2_event_fifo #(
        .W     (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (emit),
        .din   (ev_word),
        .pop   (fifo_pop),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign ev_valid = !fifo_empty;
    assign ev_code  = head[7:0];
    assign ev_break = head[EV_BRK_BIT];
    assign ev_ext   = head[EV_EXT_BIT];
    assign busy     = (state_q != ST_IDLE);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Bench for ps2_key_event_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a flag-and-queue reference model.
module tb_ps2_key_event_ctrl;

    localparam int DEPTH = 4;
    localparam int TO    = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_break;
    logic       ev_ext;
    logic       busy;
    logic       overflow;
    logic       clr_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    ps2_key_event_ctrl #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_code      (ev_code),
        .ev_break     (ev_break),
        .ev_ext       (ev_ext),
        .busy         (busy),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    // Reference model: prefix flags, quiet-cycle count, event queue, sticky overflow.
    logic [9:0] mq[$];
    logic       m_ovf, m_seq, m_ext, m_brk;
    int         m_quiet;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_status(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf   = 1'b0;
        m_seq   = 1'b0;
        m_ext   = 1'b0;
        m_brk   = 1'b0;
        m_quiet = 0;
    endtask

    task automatic model_step();
        logic       pop, full, emit, drop;
        logic [9:0] ev;
        pop  = (mq.size() > 0) && ev_ready;
        full = (mq.size() == DEPTH);
        emit = 1'b0;
        ev   = '0;
        if (rx_done_tick) begin
            m_quiet = 0;
            if (rx_data == 8'hE0) begin
                m_seq = 1'b1;
                m_ext = 1'b1;
            end else if (rx_data == 8'hF0) begin
                m_seq = 1'b1;
                m_brk = 1'b1;
            end else if (m_seq || !is_status(rx_data)) begin
                emit  = 1'b1;
                ev    = {m_ext, m_brk, rx_data};
                m_seq = 1'b0;
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end else if (m_seq) begin
            if (m_quiet == TO - 1) begin
                m_seq   = 1'b0;
                m_ext   = 1'b0;
                m_brk   = 1'b0;
                m_quiet = 0;
            end else begin
                m_quiet++;
            end
        end
        drop = emit && full && !pop;
        if (pop) void'(mq.pop_front());
        if (emit && !drop) mq.push_back(ev);
        if (drop) m_ovf = 1'b1;
        else if (clr_overflow) m_ovf = 1'b0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (reset !== 1'b1) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                check("cmp_valid", ev_valid, mq.size() > 0);
                if (mq.size() > 0) begin
                    check("cmp_code", ev_code, mq[0][7:0]);
                    check("cmp_break", ev_break, mq[0][8]);
                    check("cmp_ext", ev_ext, mq[0][9]);
                end
                check("cmp_busy", busy, m_seq);
                check("cmp_overflow", overflow, m_ovf);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_done_tick = 1'b1;
        rx_data      = b;
        cycle();
        rx_done_tick = 1'b0;
        rx_data      = 8'($urandom);
    endtask

    task automatic expect_ev(input string name, input logic ext, input logic brk, input logic [7:0] code);
        check({name, "_valid"}, ev_valid, 1'b1);
        check({name, "_code"}, ev_code, code);
        check({name, "_break"}, ev_break, brk);
        check({name, "_ext"}, ev_ext, ext);
    endtask

    logic [7:0] codes [5] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    logic [7:0] after6 [4] = '{8'h1E, 8'h26, 8'h25, 8'h36};
    logic [7:0] st_bytes [6] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

    initial begin
        int k;
        int n;
        int phase;
        logic do_tick;
        reset        = 1'b0;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        ev_ready     = 1'b0;
        clr_overflow = 1'b0;
        repeat (3) cycle();
        check("rst_valid", ev_valid, 1'b0);
        check("rst_code", ev_code, 8'h00);
        check("rst_break", ev_break, 1'b0);
        check("rst_ext", ev_ext, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        reset = 1'b1;
        cycle();

        // Make then break of a plain key.
        ev_ready = 1'b1;
        send(8'h1C);
        expect_ev("t1_make", 1'b0, 1'b0, 8'h1C);
        send(8'hF0);
        check("t1_busy", busy, 1'b1);
        send(8'h1C);
        expect_ev("t1_break", 1'b0, 1'b1, 8'h1C);
        check("t1_ovf", overflow, 1'b0);

        // Extended make and break.
        send(8'hE0);
        check("t2_busy_e0", busy, 1'b1);
        send(8'h75);
        expect_ev("t2_make", 1'b1, 1'b0, 8'h75);
        check("t2_idle", busy, 1'b0);
        send(8'hE0);
        send(8'hF0);
        check("t2_busy_e0f0", busy, 1'b1);
        send(8'h75);
        expect_ev("t2_break", 1'b1, 1'b1, 8'h75);

        // Status bytes filtered only in IDLE.
        send(8'hAA);
        check("t3_aa", ev_valid, 1'b0);
        send(8'hFA);
        check("t3_fa", ev_valid, 1'b0);
        send(8'h00);
        check("t3_00", ev_valid, 1'b0);
        send(8'hF0);
        send(8'hAA);
        expect_ev("t3_brk_aa", 1'b0, 1'b1, 8'hAA);

        // Timeout after a lone prefix.
        send(8'hE0);
        k = 0;
        while (busy === 1'b1 && k < 2 * TO) begin
            cycle();
            k++;
        end
        check("t4_timeout_cycles", k, TO);
        send(8'h1C);
        expect_ev("t4_after_to", 1'b0, 1'b0, 8'h1C);

        // A byte landing on the timeout cycle wins.
        send(8'hE0);
        repeat (TO - 1) cycle();
        check("t4_busy_edge", busy, 1'b1);
        send(8'h1C);
        expect_ev("t4_byte_wins", 1'b1, 1'b0, 8'h1C);
        cycle();
        ev_ready = 1'b0;

        // Overflow with consumer stalled, then ordered drain and clear.
        for (int i = 0; i < 5; i++) send(codes[i]);
        check("t5_ovf_set", overflow, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("t5_drain", ev_code, codes[i]);
            ev_ready = 1'b1;
            cycle();
            ev_ready = 1'b0;
        end
        check("t5_empty", ev_valid, 1'b0);
        check("t5_ovf_sticky", overflow, 1'b1);
        clr_overflow = 1'b1;
        cycle();
        clr_overflow = 1'b0;
        check("t5_ovf_clr", overflow, 1'b0);

        // Full queue with push and pop together: nothing dropped.
        for (int i = 0; i < 4; i++) send(codes[i]);
        ev_ready = 1'b1;
        send(8'h36);
        ev_ready = 1'b0;
        check("t6_no_drop", overflow, 1'b0);
        n = 0;
        while (ev_valid === 1'b1 && n < 8) begin
            if (n < 4) check("t6_drain", ev_code, after6[n]);
            ev_ready = 1'b1;
            cycle();
            ev_ready = 1'b0;
            n++;
        end
        check("t6_count", n, 4);

        // Reset mid-sequence discards queue and partial sequence.
        send(8'h1C);
        send(8'hF0);
        check("t6_pre_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("t6_rst_valid", ev_valid, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_code", ev_code, 8'h00);
        cycle();
        reset = 1'b1;
        cycle();
        send(8'h1C);
        expect_ev("t6_after_rst", 1'b0, 1'b0, 8'h1C);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            phase        = (c / 300) % 3;
            ev_ready     = (phase == 2) ? ($urandom_range(9) == 0) : ($urandom_range(3) != 0);
            clr_overflow = ($urandom_range(40) == 0);
            do_tick      = (phase == 1) ? ($urandom_range(59) == 0) : ($urandom_range(2) == 0);
            rx_done_tick = do_tick;
            case ($urandom_range(9))
                0:       rx_data = 8'hE0;
                1:       rx_data = 8'hF0;
                2:       rx_data = st_bytes[$urandom_range(5)];
                default: rx_data = 8'($urandom);
            endcase
            cycle();
        end
        rx_done_tick = 1'b0;
        ev_ready     = 1'b0;
        clr_overflow = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
